jpu_lsu: RTL and testbench
==========================

Name: jpu_lsu

Overview:
Parametrised load/store unit between the jpu execute stage and the data bus master. Generalises the fixed 32-bit word/half/byte alignment logic to DATA_W of 32 or 64 and adds an optional mode that splits misaligned accesses into two bus beats. Runs a sequential request/response FSM: one access outstanding, one bus beat in flight at a time, with sign extension and beat merge on read return.

Parameters:
DATA_W, 32, bus/data width in bits; legal values 32 or 64; NB=DATA_W/8, LSB_W=log2(NB)
ADDR_W, 32, byte address width
MISALIGN_SPLIT, 1, 1: access not aligned to its size is split into two beats; 0: it raises err_o

Ports:
clk  in  1  clock
rst_b  in  1  reset; asynchronous, active-low
req_i  in  1  core access request; sampled only when ready_o=1
we_i  in  1  1=store, 0=load
size_i  in  2  0=byte, 1=half, 2=word, 3=dword (dword legal only when DATA_W=64)
se_i  in  1  sign-extend load result
addr_i  in  ADDR_W  byte address
wdata_i  in  DATA_W  store data, LSB-justified
ready_o  out  1  high in IDLE only
resp_valid_o  out  1  one-cycle pulse: access completed without error
rdata_o  out  DATA_W  load result, LSB-justified, zero- or sign-extended; valid with resp_valid_o
err_o  out  1  one-cycle pulse: access aborted
bus_req_o  out  1  bus beat request
bus_we_o  out  1  beat is a write
bus_addr_o  out  ADDR_W-LSB_W  word address
bus_mask_o  out  NB  byte enables
bus_wdata_o  out  DATA_W  aligned write data
bus_stall_i  in  1  beat not accepted this cycle
bus_rvalid_i  in  1  read data return (>=1 cycle after acceptance)
bus_rdata_i  in  DATA_W  read data
bus_err_i  in  1  beat error, reported in place of rvalid/acceptance

Behaviour:
- Reset: FSM=IDLE; all outputs 0 except ready_o=1; capture registers cleared. Reset asserted mid-access aborts it with no resp/err pulse.
- Capture: on req_i & ready_o, latch we, size, se, addr, wdata; next state REQ0.
- Geometry: bytes=1<<size_i; off=addr[LSB_W-1:0]; misaligned=(off & (bytes-1))!=0; cross=(off+bytes)>NB. Extended mask = ((1<<bytes)-1)<<off over 2*NB bits; extended wdata = wdata<<(8*off) over 2*DATA_W bits. Beat0 uses the low halves at word addr>>LSB_W; beat1 uses the high halves at word+1 (wraps modulo 2^(ADDR_W-LSB_W)).
- Illegal (size=3 with DATA_W=32, or misaligned with MISALIGN_SPLIT=0): go to ERR; err_o pulses the cycle after capture; no bus beat issued.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, ERR.
- REQn: bus_req_o=1, address/mask/data stable while bus_stall_i=1. On accept (req & ~stall): read -> WAITn; write -> REQ1 if n=0 & cross, else DONE.
- WAITn: bus_req_o=0; on bus_rvalid_i store bytes under mask into the merge buffer; then REQ1 if n=0 & cross, else DONE.
- bus_err_i in REQn or WAITn: go to ERR; beat1 is never issued after a beat0 error.
- DONE: resp_valid_o=1 for one cycle; rdata_o = merged bytes >>(8*off), truncated to `bytes`, extended per se_i; 0 for writes. Then IDLE.
- ERR: err_o=1 for one cycle; then IDLE.
- Latency, zero stall: aligned store resp at T+2 (T=capture cycle); aligned load resp 1 cycle after bus_rvalid_i; split access adds one beat.
- bus_rvalid_i/bus_err_i seen in IDLE are ignored. resp_valid_o and err_o are never high together.
- A req_i arriving in the DONE/ERR cycle is not accepted, since ready_o=0.

Test Plan:
- DATA_W=32: lh, se=1, addr 0x1002, bus_rdata 0x8001_1234 -> beat word 0x400, mask 1100; rdata_o=0xFFFF_8001, one resp pulse.
- Split lw at 0x1003: beat0 word 0x400, mask 1000, data 0xAABBCCDD; beat1 word 0x401, mask 0111, data 0x11223344 -> rdata_o=0x223344AA.
- Split sw 0xDEADBEEF at 0x1002 -> beat0 word 0x400, mask 1100, wdata 0xBEEF0000; beat1 word 0x401, mask 0011, wdata 0x0000DEAD; resp after beat1 accept.
- bus_stall_i held 3 cycles in REQ0 -> bus_addr/mask/wdata constant, exactly one accept, no early resp.
- bus_err_i on beat0 of a split load -> err_o single pulse, bus_req_o never asserted for word 0x401, ready_o back to 1.
- MISALIGN_SPLIT=0, lw at 0x1001 -> err_o at T+1, bus_req_o stays 0. DATA_W=64: ld at 0x2008 -> word 0x401, mask 0xFF, single beat.
- rst_b pulsed low in WAIT0 -> outputs reset immediately; a late bus_rvalid_i is ignored; no resp or err.

Source files
------------

// File: rtl/jpu_lsu.sv
// Load/store unit for the jpu execute stage: one access outstanding, misaligned
// accesses optionally split into two bus beats, read data merged and extended.
module jpu_lsu #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_b,
  input  logic                                req_i,
  input  logic                                we_i,
  input  logic [1:0]                          size_i,
  input  logic                                se_i,
  input  logic [ADDR_W-1:0]                   addr_i,
  input  logic [DATA_W-1:0]                   wdata_i,
  output logic                                ready_o,
  output logic                                resp_valid_o,
  output logic [DATA_W-1:0]                   rdata_o,
  output logic                                err_o,
  output logic                                bus_req_o,
  output logic                                bus_we_o,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]  bus_addr_o,
  output logic [DATA_W/8-1:0]                 bus_mask_o,
  output logic [DATA_W-1:0]                   bus_wdata_o,
  input  logic                                bus_stall_i,
  input  logic                                bus_rvalid_i,
  input  logic [DATA_W-1:0]                   bus_rdata_i,
  input  logic                                bus_err_i
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned LSB_W    = $clog2(NB);
  localparam int unsigned WA_W     = ADDR_W - LSB_W;
  localparam bit          DWORD_OK = (DATA_W == 64);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq0  = 3'd1;
  localparam logic [2:0] StWait0 = 3'd2;
  localparam logic [2:0] StReq1  = 3'd3;
  localparam logic [2:0] StWait1 = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  logic [2:0]          r_state, w_state_d;
  logic                r_we, r_se;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2*DATA_W-1:0] r_merge, w_merge_d;

  // Legality is judged on the incoming request so ERR follows capture directly.
  logic [3:0]       w_in_bytes_m1;
  logic [LSB_W-1:0] w_in_off;
  logic             w_in_illegal;

  always_comb begin
    w_in_bytes_m1 = (4'd1 << size_i) - 4'd1;
    w_in_off      = addr_i[LSB_W-1:0];
    w_in_illegal  = ((size_i == 2'd3) && !DWORD_OK) ||
                    (((w_in_off & w_in_bytes_m1[LSB_W-1:0]) != '0) && !MISALIGN_SPLIT);
  end

  logic [3:0]          w_bytes;
  logic [LSB_W-1:0]    w_off;
  logic                w_cross, w_hi, w_in_req;
  logic [2*NB-1:0]     w_base, w_ext_mask;
  logic [NB-1:0]       w_beat_mask;
  logic [2*DATA_W-1:0] w_ext_wdata;

  always_comb begin
    w_bytes = 4'd1 << r_size;
    w_off   = r_addr[LSB_W-1:0];
    w_cross = ({1'b0, 4'(w_off)} + {1'b0, w_bytes}) > 5'(NB);
    w_base  = '0;
    for (int i = 0; i < 2 * NB; i++) w_base[i] = (i < int'(w_bytes));
    w_ext_mask  = w_base << w_off;
    w_ext_wdata = {{DATA_W{1'b0}}, r_wdata} << {w_off, 3'b000};
    w_hi        = (r_state == StReq1) || (r_state == StWait1);
    w_in_req    = (r_state == StReq0) || (r_state == StReq1);
    w_beat_mask = w_hi ? w_ext_mask[2*NB-1:NB] : w_ext_mask[NB-1:0];
  end

  always_comb begin
    ready_o     = (r_state == StIdle);
    bus_req_o   = w_in_req;
    bus_we_o    = w_in_req & r_we;
    bus_addr_o  = '0;
    bus_mask_o  = '0;
    bus_wdata_o = '0;
    if (w_in_req) begin
      bus_addr_o  = r_addr[ADDR_W-1:LSB_W] + WA_W'(w_hi);
      bus_mask_o  = w_beat_mask;
      bus_wdata_o = w_hi ? w_ext_wdata[2*DATA_W-1:DATA_W] : w_ext_wdata[DATA_W-1:0];
    end
  end

  // Beat 0 fills the low half of the merge buffer, beat 1 the high half.
  always_comb begin
    w_merge_d = r_merge;
    if (bus_rvalid_i && ((r_state == StWait0) || (r_state == StWait1))) begin
      for (int i = 0; i < NB; i++) begin
        if (w_beat_mask[i]) begin
          if (w_hi) w_merge_d[DATA_W+8*i +: 8] = bus_rdata_i[8*i +: 8];
          else      w_merge_d[8*i +: 8]        = bus_rdata_i[8*i +: 8];
        end
      end
    end
  end

  logic [2*DATA_W-1:0] w_shifted;
  logic                w_sign;
  logic [DATA_W-1:0]   w_result;

  always_comb begin
    w_shifted = r_merge >> {w_off, 3'b000};
    w_sign    = 1'b0;
    w_result  = '0;
    for (int i = 0; i < NB; i++) begin
      if (i == int'(w_bytes) - 1) w_sign = w_shifted[8*i+7];
    end
    for (int i = 0; i < NB; i++) begin
      w_result[8*i +: 8] = (i < int'(w_bytes)) ? w_shifted[8*i +: 8] : {8{r_se & w_sign}};
    end
    resp_valid_o = (r_state == StDone);
    err_o        = (r_state == StErr);
    rdata_o      = (resp_valid_o && !r_we) ? w_result : '0;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: if (req_i) w_state_d = w_in_illegal ? StErr : StReq0;
      StReq0: begin
        if (bus_err_i)         w_state_d = StErr;
        else if (!bus_stall_i) w_state_d = !r_we ? StWait0 : (w_cross ? StReq1 : StDone);
      end
      StWait0: begin
        if (bus_err_i)         w_state_d = StErr;
        else if (bus_rvalid_i) w_state_d = w_cross ? StReq1 : StDone;
      end
      StReq1: begin
        if (bus_err_i)         w_state_d = StErr;
        else if (!bus_stall_i) w_state_d = r_we ? StDone : StWait1;
      end
      StWait1: begin
        if (bus_err_i)         w_state_d = StErr;
        else if (bus_rvalid_i) w_state_d = StDone;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_se    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_merge <= '0;
    end else begin
      r_state <= w_state_d;
      r_merge <= w_merge_d;
      if (ready_o && req_i) begin
        r_we    <= we_i;
        r_se    <= se_i;
        r_size  <= size_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_jpu_lsu.sv
// Bench for jpu_lsu: randomized loads/stores against a byte-addressed reference memory,
// plus directed cases for the 32-bit no-split and 64-bit configurations.
module tb_jpu_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_b;

  logic        a_req, a_we, a_se, a_ready, a_resp, a_err, a_breq, a_bwe, a_stall, a_rvalid, a_berr;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata, a_bwdata, a_brdata;
  logic [29:0] a_baddr;
  logic [3:0]  a_bmask;

  logic        b_req, b_we, b_se, b_ready, b_resp, b_err, b_breq, b_bwe, b_stall, b_rvalid, b_berr;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata, b_bwdata, b_brdata;
  logic [29:0] b_baddr;
  logic [3:0]  b_bmask;

  logic        c_req, c_we, c_se, c_ready, c_resp, c_err, c_breq, c_bwe, c_stall, c_rvalid, c_berr;
  logic [1:0]  c_size;
  logic [31:0] c_addr;
  logic [63:0] c_wdata, c_rdata, c_bwdata, c_brdata;
  logic [28:0] c_baddr;
  logic [7:0]  c_bmask;

  jpu_lsu #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_dut_a (
    .clk(clk), .rst_b(rst_b), .req_i(a_req), .we_i(a_we), .size_i(a_size), .se_i(a_se),
    .addr_i(a_addr), .wdata_i(a_wdata), .ready_o(a_ready), .resp_valid_o(a_resp),
    .rdata_o(a_rdata), .err_o(a_err), .bus_req_o(a_breq), .bus_we_o(a_bwe),
    .bus_addr_o(a_baddr), .bus_mask_o(a_bmask), .bus_wdata_o(a_bwdata),
    .bus_stall_i(a_stall), .bus_rvalid_i(a_rvalid), .bus_rdata_i(a_brdata), .bus_err_i(a_berr)
  );

  jpu_lsu #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_dut_b (
    .clk(clk), .rst_b(rst_b), .req_i(b_req), .we_i(b_we), .size_i(b_size), .se_i(b_se),
    .addr_i(b_addr), .wdata_i(b_wdata), .ready_o(b_ready), .resp_valid_o(b_resp),
    .rdata_o(b_rdata), .err_o(b_err), .bus_req_o(b_breq), .bus_we_o(b_bwe),
    .bus_addr_o(b_baddr), .bus_mask_o(b_bmask), .bus_wdata_o(b_bwdata),
    .bus_stall_i(b_stall), .bus_rvalid_i(b_rvalid), .bus_rdata_i(b_brdata), .bus_err_i(b_berr)
  );

  jpu_lsu #(.DATA_W(64), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_dut_c (
    .clk(clk), .rst_b(rst_b), .req_i(c_req), .we_i(c_we), .size_i(c_size), .se_i(c_se),
    .addr_i(c_addr), .wdata_i(c_wdata), .ready_o(c_ready), .resp_valid_o(c_resp),
    .rdata_o(c_rdata), .err_o(c_err), .bus_req_o(c_breq), .bus_we_o(c_bwe),
    .bus_addr_o(c_baddr), .bus_mask_o(c_bmask), .bus_wdata_o(c_bwdata),
    .bus_stall_i(c_stall), .bus_rvalid_i(c_rvalid), .bus_rdata_i(c_brdata), .bus_err_i(c_berr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference memory (bytes from 0x1000) and bus-side word memory (words from 0x400).
  logic [7:0]  bmem [0:255];
  logic [31:0] wmem [0:63];

  task automatic set_word(input logic [29:0] w, input logic [31:0] v);
    int idx;
    idx = int'(w) - 'h400;
    wmem[idx] = v;
    for (int k = 0; k < 4; k++) bmem[4*idx+k] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] slave_rd(input logic [29:0] w);
    if (w >= 30'h400 && w < 30'h440) return wmem[int'(w) - 'h400];
    return 32'h0;
  endfunction

  task automatic slave_wr(input logic [29:0] w, input logic [3:0] m, input logic [31:0] d);
    if (w >= 30'h400 && w < 30'h440)
      for (int k = 0; k < 4; k++) if (m[k]) wmem[int'(w) - 'h400][8*k +: 8] = d[8*k +: 8];
  endtask

  bit          stall_en, err_en, force_err0, inj_err, late_req, got_resp, got_err;
  int          force_stall, lat, nb;
  logic [31:0] got_rdata;
  logic [29:0] bt_addr  [4];
  logic [3:0]  bt_mask  [4];
  logic [31:0] bt_wdata [4];
  logic        bt_we    [4];

  // Issue one access on DUT a and play the bus slave until resp/err or a cycle budget expires.
  task automatic a_access(input logic we, input logic [1:0] size, input logic se,
                          input logic [31:0] addr, input logic [31:0] wdata);
    int cnt, stall_left;
    bit held;
    logic [29:0] pend, s_addr;
    logic [3:0]  s_mask;
    logic [31:0] s_wd;
    check_val("ready_idle", a_ready, 1);
    a_req = 1'b1; a_we = we; a_size = size; a_se = se; a_addr = addr; a_wdata = wdata;
    @(negedge clk);
    a_req = 1'b0; a_we = 1'($urandom); a_size = 2'($urandom); a_se = 1'($urandom);
    a_addr = $urandom; a_wdata = $urandom;
    got_resp = 0; got_err = 0; got_rdata = '0; lat = 0; nb = 0; inj_err = 0; late_req = 0;
    cnt = 0; held = 0; stall_left = force_stall; pend = '0;
    s_addr = '0; s_mask = '0; s_wd = '0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      a_stall = 1'b0; a_rvalid = 1'b0; a_berr = 1'b0; a_brdata = $urandom;
      if (a_resp || a_err) begin
        got_resp = a_resp; got_err = a_err; got_rdata = a_rdata; lat = i;
        check_val("resp_err_excl", a_resp & a_err, 0);
      end else begin
        if (a_breq) begin
          if (inj_err) late_req = 1;
          if (held) begin
            check_val("stall_addr", a_baddr, s_addr);
            check_val("stall_mask", a_bmask, s_mask);
            check_val("stall_wdata", a_bwdata, s_wd);
          end
          held = 0;
          if (stall_left > 0) begin
            stall_left--;
            a_stall = 1'b1;
          end else if (stall_en && $urandom_range(0, 3) == 0) begin
            a_stall = 1'b1;
          end else if ((force_err0 && nb == 0) || (err_en && !we && $urandom_range(0, 9) == 0)) begin
            a_berr = 1'b1; inj_err = 1;
          end else begin
            if (nb < 4) begin
              bt_addr[nb] = a_baddr; bt_mask[nb] = a_bmask; bt_wdata[nb] = a_bwdata; bt_we[nb] = a_bwe;
            end
            nb++;
            if (a_bwe) slave_wr(a_baddr, a_bmask, a_bwdata);
            else begin
              pend = a_baddr;
              cnt = stall_en ? int'($urandom_range(1, 3)) : 1;
            end
          end
          if (a_stall) begin
            held = 1; s_addr = a_baddr; s_mask = a_bmask; s_wd = a_bwdata;
          end
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            if (err_en && $urandom_range(0, 9) == 0) begin
              a_berr = 1'b1; inj_err = 1;
            end else begin
              a_rvalid = 1'b1; a_brdata = slave_rd(pend);
            end
          end
        end
        @(negedge clk);
      end
    end
    a_stall = 1'b0; a_rvalid = 1'b0; a_berr = 1'b0;
    check_val("complete", lat != 0, 1);
    if (lat != 0) begin
      @(negedge clk);
      check_val("pulse_once", {a_resp, a_err}, 0);
      check_val("ready_after", a_ready, 1);
    end
  endtask

  // Run an access and judge it against the byte-level reference.
  task automatic a_txn(input logic we, input logic [1:0] size, input logic se,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n, w0, w1, exp_nb, ba;
    logic [3:0]  m;
    logic [31:0] exp_rd;
    a_access(we, size, se, addr, wdata);
    if (size == 2'd3) begin
      check_val("illegal_err", got_err, 1);
      check_val("illegal_nobeat", nb, 0);
      check_val("illegal_lat", lat, 1);
      return;
    end
    if (inj_err) begin
      check_val("buserr_err", got_err, 1);
      check_val("buserr_noresp", got_resp, 0);
      check_val("buserr_nomore", late_req, 0);
      return;
    end
    check_val("resp", got_resp, 1);
    check_val("resp_noerr", got_err, 0);
    n = 1 << size;
    w0 = int'(addr) >> 2;
    w1 = (int'(addr) + n - 1) >> 2;
    exp_nb = (w0 == w1) ? 1 : 2;
    check_val("beats", nb, exp_nb);
    for (int k = 0; k < exp_nb && k < nb; k++) begin
      m = '0;
      for (int j = 0; j < n; j++) begin
        ba = int'(addr) + j;
        if ((ba >> 2) == w0 + k) begin
          m[ba & 3] = 1'b1;
          if (we) check_val("beat_wdata", bt_wdata[k][8*(ba & 3) +: 8], wdata[8*j +: 8]);
        end
      end
      check_val("beat_addr", bt_addr[k], w0 + k);
      check_val("beat_mask", bt_mask[k], m);
      check_val("beat_we", bt_we[k], we);
    end
    exp_rd = '0;
    if (we) begin
      for (int j = 0; j < n; j++) bmem[int'(addr) - 'h1000 + j] = wdata[8*j +: 8];
    end else begin
      for (int j = 0; j < n; j++) exp_rd[8*j +: 8] = bmem[int'(addr) - 'h1000 + j];
      if (se && n < 4 && exp_rd[8*n-1])
        for (int j = n; j < 4; j++) exp_rd[8*j +: 8] = 8'hFF;
    end
    check_val("rdata", got_rdata, exp_rd);
  endtask

  initial begin
    logic [1:0] sz;
    rst_b = 1'b0;
    {a_req, a_we, a_se, a_stall, a_rvalid, a_berr} = '0;
    {b_req, b_we, b_se, b_stall, b_rvalid, b_berr} = '0;
    {c_req, c_we, c_se, c_stall, c_rvalid, c_berr} = '0;
    a_size = '0; a_addr = '0; a_wdata = '0; a_brdata = '0;
    b_size = '0; b_addr = '0; b_wdata = '0; b_brdata = '0;
    c_size = '0; c_addr = '0; c_wdata = '0; c_brdata = '0;
    stall_en = 0; err_en = 0; force_err0 = 0; force_stall = 0;
    for (int i = 0; i < 64; i++) set_word(30'(32'h400 + i), $urandom);
    repeat (2) @(negedge clk);
    check_val("rst_ready", a_ready, 1);
    check_val("rst_outs", {a_resp, a_err, a_breq, a_bwe, a_bmask}, 0);
    check_val("rst_data", {a_rdata, a_bwdata}, 0);
    check_val("rst_addr", a_baddr, 0);
    rst_b = 1'b1;
    @(negedge clk);

    set_word(30'h400, 32'h8001_1234);
    a_txn(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0);
    check_val("lh_addr", bt_addr[0], 30'h400);
    check_val("lh_mask", bt_mask[0], 4'b1100);
    check_val("lh_rdata", got_rdata, 32'hFFFF_8001);
    check_val("lh_lat", lat, 3);

    set_word(30'h400, 32'hAABB_CCDD);
    set_word(30'h401, 32'h1122_3344);
    a_txn(1'b0, 2'd2, 1'b0, 32'h1003, 32'h0);
    check_val("slw_rdata", got_rdata, 32'h2233_44AA);
    check_val("slw_mask0", bt_mask[0], 4'b1000);
    check_val("slw_mask1", bt_mask[1], 4'b0111);
    check_val("slw_addr1", bt_addr[1], 30'h401);
    check_val("slw_lat", lat, 5);

    a_txn(1'b1, 2'd2, 1'b0, 32'h1002, 32'hDEAD_BEEF);
    check_val("ssw_wd0", bt_wdata[0], 32'hBEEF_0000);
    check_val("ssw_wd1", bt_wdata[1], 32'h0000_DEAD);
    check_val("ssw_mask0", bt_mask[0], 4'b1100);
    check_val("ssw_mask1", bt_mask[1], 4'b0011);
    check_val("ssw_lat", lat, 3);

    a_txn(1'b1, 2'd2, 1'b0, 32'h1008, 32'h1234_5678);
    check_val("sw_lat", lat, 2);

    force_stall = 3;
    a_txn(1'b1, 2'd2, 1'b0, 32'h1010, 32'h0BAD_F00D);
    force_stall = 0;
    check_val("stall_lat", lat, 5);

    force_err0 = 1;
    a_txn(1'b0, 2'd2, 1'b0, 32'h1006, 32'h0);
    force_err0 = 0;
    check_val("err0_beats", nb, 0);

    stall_en = 1; err_en = 1;
    for (int t = 0; t < 200; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a_txn(1'($urandom), sz, 1'($urandom), 32'h1000 + $urandom_range(0, 240), $urandom);
    end
    stall_en = 0; err_en = 0;

    a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_se = 1'b0; a_addr = 32'h1004;
    @(negedge clk);
    a_req = 1'b0;
    check_val("rst_mid_req0", a_breq, 1);
    @(negedge clk);
    check_val("rst_mid_wait0", {a_breq, a_ready}, 0);
    rst_b = 1'b0;
    #1;
    check_val("rst_mid_ready", a_ready, 1);
    check_val("rst_mid_outs", {a_resp, a_err, a_breq}, 0);
    @(negedge clk);
    rst_b = 1'b1; a_rvalid = 1'b1; a_brdata = 32'hCAFE_0001;
    @(negedge clk);
    a_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("rst_late_quiet", {a_resp, a_err, a_breq}, 0);
      check_val("rst_late_ready", a_ready, 1);
      @(negedge clk);
    end

    b_req = 1'b1; b_we = 1'b0; b_size = 2'd2; b_addr = 32'h1001;
    @(negedge clk);
    b_req = 1'b0;
    check_val("ns_err", b_err, 1);
    check_val("ns_nobus", b_breq, 0);
    check_val("ns_noresp", b_resp, 0);
    @(negedge clk);
    check_val("ns_err_once", b_err, 0);
    check_val("ns_ready", b_ready, 1);
    check_val("ns_nobus2", b_breq, 0);

    c_req = 1'b1; c_we = 1'b0; c_size = 2'd3; c_se = 1'b0; c_addr = 32'h2008;
    @(negedge clk);
    c_req = 1'b0;
    check_val("ld_req", c_breq, 1);
    check_val("ld_addr", c_baddr, 29'h401);
    check_val("ld_mask", c_bmask, 8'hFF);
    @(negedge clk);
    check_val("ld_single", c_breq, 0);
    c_rvalid = 1'b1; c_brdata = 64'h8877_6655_4433_2211;
    @(negedge clk);
    c_rvalid = 1'b0;
    check_val("ld_resp", c_resp, 1);
    check_val("ld_rdata", c_rdata, 64'h8877_6655_4433_2211);
    @(negedge clk);
    check_val("ld_idle", {c_breq, c_resp, c_ready}, 3'b001);

    c_req = 1'b1; c_size = 2'd0; c_se = 1'b1; c_addr = 32'h2005;
    @(negedge clk);
    c_req = 1'b0;
    check_val("lb64_addr", c_baddr, 29'h400);
    check_val("lb64_mask", c_bmask, 8'h20);
    @(negedge clk);
    c_rvalid = 1'b1; c_brdata = 64'h0000_8600_0000_0000;
    @(negedge clk);
    c_rvalid = 1'b0;
    check_val("lb64_resp", c_resp, 1);
    check_val("lb64_rdata", c_rdata, 64'hFFFF_FFFF_FFFF_FF86);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
